// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S DAC transmit path: the sample width, the
// serializer state encoding and the LRCK level that marks the left channel.
// ---------------------------------------------------------------------------
package i2s_pkg;

   // Sample width in bits; also the number of data slots sent per channel.
   localparam int DATA_W = 16;

   // AUD_DACLRCK level that selects the left channel.
   localparam logic LRCK_LEFT = 1'b0;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_FALL = 3'd1,
      WAIT_RISE = 3'd2,
      DELAY     = 3'd3,
      SHIFT     = 3'd4
   } dac_state_t;

endpackage

// File: rtl/dac_serializer_if.sv
// ---------------------------------------------------------------------------
// dac_serializer_if
// Player <-> serializer handshake.
//   request_play_data : serializer -> player, one-cycle "send next sample"
//   play_data         : player -> serializer, two's complement sample
//   play_valid        : player -> serializer, play_data valid this cycle
// Modports: master = player side, slave = serializer side.
// ---------------------------------------------------------------------------
interface dac_serializer_if;
   import i2s_pkg::*;

   logic              request_play_data;
   logic [DATA_W-1:0] play_data;
   logic              play_valid;

   modport master (
      input  request_play_data,
      output play_data,
      output play_valid
   );

   modport slave (
      output request_play_data,
      input  play_data,
      input  play_valid
   );

endinterface

// File: rtl/dac_shifter.sv
// ---------------------------------------------------------------------------
// dac_shifter
// Loadable MSB-first shift register with a bit counter.
//   clk         : bit clock, flops update on the falling edge
//   rst         : synchronous active-high reset
//   load_i      : load load_data_i and clear the counter
//   load_data_i : word to serialize
//   shift_i     : shift left one place and advance the counter
//   msb_o       : current MSB (the bit being sent)
//   done_o      : counter is on the last bit of the word
// ---------------------------------------------------------------------------
module dac_shifter
   import i2s_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [DATA_W-1:0] load_data_i,
   input  logic              shift_i,
   output logic              msb_o,
   output logic              done_o
);

   localparam int CNT_W = $clog2(DATA_W);

   logic [DATA_W-1:0] shift_q;
   logic [CNT_W-1:0]  cnt_q;

   // Shift register and bit counter; the counter wraps to 0 after the last bit.
   always_ff @(negedge clk) begin
      if (rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (load_i) begin
         shift_q <= load_data_i;
         cnt_q   <= '0;
      end else if (shift_i) begin
         shift_q <= {shift_q[DATA_W-2:0], 1'b0};
         cnt_q   <= cnt_q + CNT_W'(1);
      end
   end

   assign msb_o  = shift_q[DATA_W-1];
   assign done_o = (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/dac_serializer.sv
// ---------------------------------------------------------------------------
// dac_serializer
// WM8731 DAC transmit path: takes PCM samples from the player through a
// one-entry buffer and sends them MSB-first in I2S format (one-slot delay
// after each LRCK edge). All flops run on the falling edge of AUD_BCLK so the
// codec can sample AUD_DACDAT on the rising edge.
//   clk               : AUD_BCLK
//   rst               : synchronous active-high reset
//   start             : level enable, registered before use
//   AUD_DACLRCK       : codec frame clock, low = left, high = right
//   AUD_DACDAT        : serial data to codec (registered)
//   underrun          : one-cycle pulse when a left frame starts with no sample
//   play              : player handshake (request_play_data/play_data/play_valid)
// Build option DAC_DUAL_MONO_EN: repeat the left sample in the right channel;
// without it the right channel is silent.
// ---------------------------------------------------------------------------
module dac_serializer
   import i2s_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            AUD_DACLRCK,
   output logic            AUD_DACDAT,
   output logic            underrun,
   dac_serializer_if.slave play
);

   dac_state_t        state_q;
   logic              lrck_q;
   logic              start_q;
   logic              dacdat_q;
   logic              req_q;
   logic              underrun_q;
   logic              buf_full_q;
   logic              buf_full_d;
   logic [DATA_W-1:0] buf_q;
   logic [DATA_W-1:0] buf_d;

   logic              fall_s;
   logic              load_left_s;
   logic              load_s;
   logic [DATA_W-1:0] load_data_s;
   logic              msb_s;
   logic              done_s;

`ifdef DAC_DUAL_MONO_EN
   logic              rise_s;
   logic              right_q;   // word in flight is the right-channel repeat
   logic [DATA_W-1:0] copy_q;    // left sample kept for the right channel
   assign rise_s = ~lrck_q & (AUD_DACLRCK != LRCK_LEFT);
`endif

   assign fall_s      = lrck_q & (AUD_DACLRCK == LRCK_LEFT);
   assign load_left_s = (state_q == WAIT_FALL) & fall_s;

   // Shifter load select: buffered sample (or silence) at a left frame start,
   // the kept copy at a right frame start.
   always_comb begin
      load_s      = 1'b0;
      load_data_s = '0;
      if (load_left_s) begin
         load_s      = 1'b1;
         load_data_s = buf_full_q ? buf_q : '0;
      end
`ifdef DAC_DUAL_MONO_EN
      else if ((state_q == WAIT_RISE) && rise_s) begin
         load_s      = 1'b1;
         load_data_s = copy_q;
      end
`endif
      else begin
         load_s      = 1'b0;
         load_data_s = '0;
      end
   end

   // One-entry buffer: a load frees the slot in the same cycle, so a sample
   // arriving with the load is kept; a sample arriving while full is dropped.
   always_comb begin
      buf_full_d = buf_full_q;
      buf_d      = buf_q;
      if (play.play_valid && (!buf_full_q || load_left_s)) begin
         buf_full_d = 1'b1;
         buf_d      = play.play_data;
      end else if (load_left_s) begin
         buf_full_d = 1'b0;
         buf_d      = buf_q;
      end else begin
         buf_full_d = buf_full_q;
         buf_d      = buf_q;
      end
   end

   dac_shifter u_shifter (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load_s),
      .load_data_i (load_data_s),
      .shift_i     (state_q == SHIFT),
      .msb_o       (msb_s),
      .done_o      (done_s)
   );

   // Frame FSM with registered data, request and underrun outputs.
   always_ff @(negedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         lrck_q     <= 1'b1;
         start_q    <= 1'b0;
         dacdat_q   <= 1'b0;
         req_q      <= 1'b0;
         underrun_q <= 1'b0;
         buf_full_q <= 1'b0;
         buf_q      <= '0;
`ifdef DAC_DUAL_MONO_EN
         right_q    <= 1'b0;
         copy_q     <= '0;
`endif
      end else begin
         lrck_q     <= AUD_DACLRCK;
         start_q    <= start;
         buf_full_q <= buf_full_d;
         buf_q      <= buf_d;
         // Data leaves the MSB one edge after SHIFT is entered; silent elsewhere.
         dacdat_q   <= (state_q == SHIFT) ? msb_s : 1'b0;
         req_q      <= 1'b0;
         underrun_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_q) begin
                  state_q <= WAIT_FALL;
                  req_q   <= 1'b1;
               end
            end
            WAIT_FALL: begin
               if (fall_s) begin
                  state_q    <= DELAY;
                  underrun_q <= ~buf_full_q;
`ifdef DAC_DUAL_MONO_EN
                  right_q    <= 1'b0;
                  copy_q     <= load_data_s;
`endif
               end
            end
`ifdef DAC_DUAL_MONO_EN
            WAIT_RISE: begin
               if (rise_s) begin
                  state_q <= DELAY;
                  right_q <= 1'b1;
               end
            end
`endif
            DELAY: begin
               state_q <= SHIFT;
`ifdef DAC_DUAL_MONO_EN
               req_q   <= ~right_q;
`else
               req_q   <= 1'b1;
`endif
            end
            SHIFT: begin
               if (done_s) begin
                  if (!start_q) begin
                     state_q <= IDLE;
`ifdef DAC_DUAL_MONO_EN
                  end else if (!right_q) begin
                     state_q <= WAIT_RISE;
`endif
                  end else begin
                     state_q <= WAIT_FALL;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign AUD_DACDAT             = dacdat_q;
   assign underrun               = underrun_q;
   assign play.request_play_data = req_q;

endmodule
